// File: rtl/mc_fifo_pkg.sv
// mc_fifo_pkg: shared defaults, error-flag bit indices and packed-slice helper for mc_fifo
package mc_fifo_pkg;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_DEPTH = 64;
    localparam int DEF_NUM_CH = 4;
    localparam int ERR_OVF = 0;
    localparam int ERR_UDF = 1;
    function automatic int slice_off(input int idx, input int width);
        return idx * width;
    endfunction
endpackage

// File: rtl/mc_fifo_chan.sv
// mc_fifo_chan: one FIFO channel (storage, wrap-bit pointers, flags, sticky errors); MC_FIFO_FWFT_EN selects first-word-fall-through read
module mc_fifo_chan import mc_fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic [1:0]            err
);
    localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] AF = (ADDR_WIDTH+1)'(AF_THRESH);
    logic [ADDR_WIDTH:0] wp, rp;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic push_ok, pop_ok;
    assign empty = wp == rp;
    assign full = (wp[ADDR_WIDTH-1:0] == rp[ADDR_WIDTH-1:0]) && (wp[ADDR_WIDTH] != rp[ADDR_WIDTH]);
    assign count = wp - rp;
    assign almost_full = count >= AF;
    assign wr_ptr = wp[ADDR_WIDTH-1:0];
    assign rd_ptr = rp[ADDR_WIDTH-1:0];
    assign push_ok = push && !full && !flush;
    assign pop_ok = pop && !empty && !flush;
    // pointers and sticky errors; flush overrides any same-cycle push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            err <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
            err <= '0;
        end else begin
            if (push_ok) wp <= wp + PTR_ONE;
            if (pop_ok) rp <= rp + PTR_ONE;
            if (push && full) err[ERR_OVF] <= 1'b1;
            if (pop && empty) err[ERR_UDF] <= 1'b1;
        end
    end
    // storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (push_ok) mem[wp[ADDR_WIDTH-1:0]] <= wr_data;
    end
`ifdef MC_FIFO_FWFT_EN
    assign rd_valid = !empty;
    assign rd_data = empty ? '0 : mem[rp[ADDR_WIDTH-1:0]];
`else
    logic [DATA_WIDTH-1:0] rd_q;
    logic rv_q;
    // registered read: head word lands one cycle after an accepted pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
            rv_q <= 1'b0;
        end else begin
            rv_q <= pop_ok;
            if (pop_ok) rd_q <= mem[rp[ADDR_WIDTH-1:0]];
        end
    end
    assign rd_valid = rv_q;
    assign rd_data = rd_q;
`endif
endmodule

// File: rtl/mc_fifo.sv
// mc_fifo: NUM_CH independent synchronous FIFOs with packed per-channel ports; MC_FIFO_FWFT_EN selects first-word-fall-through read
module mc_fifo import mc_fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CH-1:0]                push,
    input  logic [NUM_CH*DATA_WIDTH-1:0]     wr_data,
    input  logic [NUM_CH-1:0]                pop,
    input  logic [NUM_CH-1:0]                flush,
    output logic [NUM_CH*DATA_WIDTH-1:0]     rd_data,
    output logic [NUM_CH-1:0]                rd_valid,
    output logic [NUM_CH-1:0]                full,
    output logic [NUM_CH-1:0]                empty,
    output logic [NUM_CH-1:0]                almost_full,
    output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] count,
    output logic [NUM_CH*ADDR_WIDTH-1:0]     wr_ptr,
    output logic [NUM_CH*ADDR_WIDTH-1:0]     rd_ptr,
    output logic [NUM_CH-1:0]                ovf,
    output logic [NUM_CH-1:0]                udf
);
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [1:0] err;
        mc_fifo_chan #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH(DEPTH),
            .AF_THRESH(AF_THRESH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_chan (
            .clk(clk),
            .rst_n(rst_n),
            .push(push[c]),
            .wr_data(wr_data[slice_off(c, DATA_WIDTH) +: DATA_WIDTH]),
            .pop(pop[c]),
            .flush(flush[c]),
            .rd_data(rd_data[slice_off(c, DATA_WIDTH) +: DATA_WIDTH]),
            .rd_valid(rd_valid[c]),
            .full(full[c]),
            .empty(empty[c]),
            .almost_full(almost_full[c]),
            .count(count[slice_off(c, ADDR_WIDTH+1) +: ADDR_WIDTH+1]),
            .wr_ptr(wr_ptr[slice_off(c, ADDR_WIDTH) +: ADDR_WIDTH]),
            .rd_ptr(rd_ptr[slice_off(c, ADDR_WIDTH) +: ADDR_WIDTH]),
            .err(err)
        );
        assign ovf[c] = err[ERR_OVF];
        assign udf[c] = err[ERR_UDF];
    end
endmodule

// File: tb/tb_mc_fifo.sv
// tb_mc_fifo: directed self-checking bench for mc_fifo (NUM_CH=4, DEPTH=8, DATA_WIDTH=16, AF_THRESH=6)
module tb_mc_fifo;
    localparam int NC = 4;
    localparam int DW = 16;
    localparam int AW = 3;
    logic clk = 1'b0;
    logic rst_n;
    logic [NC-1:0] push, pop, flush;
    logic [NC*DW-1:0] wr_data;
    logic [NC*DW-1:0] rd_data;
    logic [NC-1:0] rd_valid, full, empty, almost_full, ovf, udf;
    logic [NC*(AW+1)-1:0] count;
    logic [NC*AW-1:0] wr_ptr, rd_ptr;
    int n_checks = 0;
    int n_errors = 0;

    mc_fifo #(.DATA_WIDTH(DW), .DEPTH(8), .NUM_CH(NC), .AF_THRESH(6)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .wr_data(wr_data), .pop(pop), .flush(flush),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .count(count), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
        .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW:0] cnt(input int c);
        return count[c*(AW+1) +: AW+1];
    endfunction

    function automatic logic [DW-1:0] rdd(input int c);
        return rd_data[c*DW +: DW];
    endfunction

    task automatic set_wd(input int c, input logic [DW-1:0] v);
        wr_data[c*DW +: DW] = v;
    endtask

    task automatic pop_read(input int c, input logic [DW-1:0] exp, input string tag);
`ifdef MC_FIFO_FWFT_EN
        check({tag, "_rv"}, 64'(rd_valid[c]), 64'd1);
        check({tag, "_data"}, 64'(rdd(c)), 64'(exp));
        pop[c] = 1'b1;
        step();
        pop[c] = 1'b0;
`else
        pop[c] = 1'b1;
        step();
        pop[c] = 1'b0;
        check({tag, "_rv"}, 64'(rd_valid[c]), 64'd1);
        check({tag, "_data"}, 64'(rdd(c)), 64'(exp));
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        push = '0;
        pop = '0;
        flush = '0;
        wr_data = '0;
        repeat (3) step();
        check("rst_empty", 64'(empty), 64'hF);
        check("rst_full", 64'(full), 64'h0);
        check("rst_af", 64'(almost_full), 64'h0);
        check("rst_count", 64'(count), 64'h0);
        check("rst_rv", 64'(rd_valid), 64'h0);
        check("rst_rd", 64'(rd_data), 64'h0);
        check("rst_err", 64'({ovf, udf}), 64'h0);
        #2 rst_n = 1'b1;
        step();
        // fill channel 0
        for (int i = 1; i <= 8; i++) begin
            push[0] = 1'b1;
            set_wd(0, 16'(i));
            step();
            if (i == 5) check("af_at5", 64'(almost_full[0]), 64'd0);
            if (i == 6) check("af_at6", 64'(almost_full[0]), 64'd1);
            if (i == 7) check("full_at7", 64'(full[0]), 64'd0);
        end
        push[0] = 1'b0;
        check("ch0_full", 64'(full[0]), 64'd1);
        check("ch0_count8", 64'(cnt(0)), 64'd8);
        check("ch0_wptr", 64'(wr_ptr[2:0]), 64'd0);
        check("ch0_rptr", 64'(rd_ptr[2:0]), 64'd0);
        check("others_empty", 64'(empty[3:1]), 64'h7);
        // push while full with concurrent pop
`ifdef MC_FIFO_FWFT_EN
        check("ovf_pop_data", 64'(rdd(0)), 64'h1);
`endif
        push[0] = 1'b1;
        pop[0] = 1'b1;
        set_wd(0, 16'h0009);
        step();
        push[0] = 1'b0;
        pop[0] = 1'b0;
        check("ch0_ovf", 64'(ovf[0]), 64'd1);
        check("ch0_count7", 64'(cnt(0)), 64'd7);
        check("ch0_notfull", 64'(full[0]), 64'd0);
`ifndef MC_FIFO_FWFT_EN
        check("ovf_pop_rv", 64'(rd_valid[0]), 64'd1);
        check("ovf_pop_data", 64'(rdd(0)), 64'h1);
`endif
        for (int i = 2; i <= 8; i++) pop_read(0, 16'(i), $sformatf("ch0_pop%0d", i));
        step();
        check("ch0_rv_drop", 64'(rd_valid[0]), 64'd0);
`ifndef MC_FIFO_FWFT_EN
        check("ch0_rd_hold", 64'(rdd(0)), 64'h8);
`endif
        check("ch0_empty", 64'(empty[0]), 64'd1);
        check("ch0_ovf_sticky", 64'(ovf[0]), 64'd1);
        // pop while empty with concurrent push on channel 2
        push[2] = 1'b1;
        pop[2] = 1'b1;
        set_wd(2, 16'hBEEF);
        step();
        push[2] = 1'b0;
        pop[2] = 1'b0;
        check("ch2_udf", 64'(udf[2]), 64'd1);
        check("ch2_count1", 64'(cnt(2)), 64'd1);
`ifndef MC_FIFO_FWFT_EN
        check("ch2_rejpop_rv", 64'(rd_valid[2]), 64'd0);
`endif
        pop_read(2, 16'hBEEF, "ch2_pop");
        // channel 1 steady-state push/pop at count 3
        for (int k = 0; k < 3; k++) begin
            push[1] = 1'b1;
            set_wd(1, 16'(16'h1000 + k));
            step();
        end
        for (int k = 0; k < 20; k++) begin
`ifdef MC_FIFO_FWFT_EN
            check("ch1_stream", 64'(rdd(1)), 64'(16'h1000 + k));
`endif
            push[1] = 1'b1;
            pop[1] = 1'b1;
            set_wd(1, 16'(16'h1003 + k));
            step();
`ifndef MC_FIFO_FWFT_EN
            check("ch1_stream", 64'(rdd(1)), 64'(16'h1000 + k));
`endif
            check("ch1_count3", 64'(cnt(1)), 64'd3);
        end
        push[1] = 1'b0;
        pop[1] = 1'b0;
        check("ch1_wptr", 64'(wr_ptr[5:3]), 64'd7);
        check("ch1_rptr", 64'(rd_ptr[5:3]), 64'd4);
        check("ch1_flags", 64'({ovf[1], udf[1], full[1]}), 64'd0);
        // channel 3: overflow, drain to 5, flush with concurrent push
        for (int k = 0; k < 9; k++) begin
            push[3] = 1'b1;
            set_wd(3, 16'(16'h3000 + k));
            step();
        end
        push[3] = 1'b0;
        check("ch3_ovf", 64'(ovf[3]), 64'd1);
        for (int k = 0; k < 3; k++) pop_read(3, 16'(16'h3000 + k), "ch3_drain");
        check("ch3_count5", 64'(cnt(3)), 64'd5);
        flush[3] = 1'b1;
        push[3] = 1'b1;
        set_wd(3, 16'hDEAD);
        step();
        flush[3] = 1'b0;
        push[3] = 1'b0;
        check("flush_count", 64'(cnt(3)), 64'd0);
        check("flush_empty", 64'(empty[3]), 64'd1);
        check("flush_ovf", 64'(ovf[3]), 64'd0);
        check("flush_rv", 64'(rd_valid[3]), 64'd0);
        check("flush_wptr", 64'(wr_ptr[11:9]), 64'd0);
        push[3] = 1'b1;
        set_wd(3, 16'h0042);
        step();
        push[3] = 1'b0;
        pop_read(3, 16'h0042, "ch3_after_flush");
        // asynchronous reset in the middle of traffic
        push = 4'b0011;
        set_wd(0, 16'h5555);
        set_wd(1, 16'h6666);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", 64'(count), 64'h0);
        check("arst_empty", 64'(empty), 64'hF);
        check("arst_err", 64'({ovf, udf, full, almost_full}), 64'h0);
        check("arst_rv", 64'(rd_valid), 64'h0);
        check("arst_rd", 64'(rd_data), 64'h0);
        check("arst_ptr", 64'(wr_ptr ^ rd_ptr), 64'h0);
        push = '0;
        #3 rst_n = 1'b1;
        step();
        check("post_rst_empty", 64'(empty), 64'hF);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
